// File: rtl/sram_arb_pkg.sv
// sram_arb_pkg: shared types and constants for the SRAM arbiter slice.
// Optional feature macro: SRAM_ARB_RR_EN (round-robin arbitration instead of
// fixed priority with a starvation guard).
package sram_arb_pkg;

  // Data path width of the SRAM controller (one 16-bit word per access).
  localparam int DW = 16;

  // One mask bit per byte; the controller masks are active-low.
  localparam int WSTRB_W = DW / 8;

  // Widest word address a request record can carry. Narrower buses are
  // zero-extended into the record and sliced back down on the way out.
  localparam int AW_MAX = 32;

  // Starvation counter width; covers the legal STARVE_MAX range 1..15.
  localparam int STARVE_CNT_W = 4;

  // Number of requesting ports.
  localparam int N_PORTS = 2;

  // Which port owns the controller this cycle.
  typedef enum logic [1:0] {
    GNT_NONE = 2'd0,
    GNT_P0   = 2'd1,
    GNT_P1   = 2'd2
  } grant_e;

  // One port's request as presented to the controller.
  typedef struct packed {
    logic                read;
    logic                write;
    logic [AW_MAX-1:0]   address;
    logic [DW-1:0]       wdata;
    logic [WSTRB_W-1:0]  wstrb;
  } sram_req_t;

  // Build a request record with the controller-facing rules already applied:
  // write wins over a simultaneous read, and reads always enable both bytes.
  function automatic sram_req_t make_req(
    input logic               read,
    input logic               write,
    input logic [AW_MAX-1:0]  address,
    input logic [DW-1:0]      wdata,
    input logic [WSTRB_W-1:0] wstrb
  );
    sram_req_t r;
    r.write   = write;
    r.read    = read & ~write;
    r.address = address;
    r.wdata   = wdata;
    r.wstrb   = write ? wstrb : '0;
    return r;
  endfunction

  // A port is requesting when it wants either a read or a write.
  function automatic logic req_active(input sram_req_t r);
    return r.read | r.write;
  endfunction

endpackage

// File: rtl/sram_arbiter_if.sv
// sram_arbiter_if: bundles both requester ports and the controller-side
// request bus of the SRAM arbiter.
// The slave modport is the arbiter's view; the master modport is the view of
// the surrounding system (requesters plus SRAM controller).
// Related feature macro: SRAM_ARB_RR_EN (no effect on this interface).
interface sram_arbiter_if #(
  parameter int AW = 18,
  parameter int DW = 16
);

  // Port 0: video / screen refresh reader (high priority)
  logic              p0_read;
  logic              p0_write;
  logic [AW-1:0]     p0_address;
  logic [DW-1:0]     p0_wdata;
  logic [DW/8-1:0]   p0_wstrb;
  logic              p0_ready;
  logic              p0_rvalid;
  logic [DW-1:0]     p0_rdata;

  // Port 1: CPU data memory (low priority)
  logic              p1_read;
  logic              p1_write;
  logic [AW-1:0]     p1_address;
  logic [DW-1:0]     p1_wdata;
  logic [DW/8-1:0]   p1_wstrb;
  logic              p1_ready;
  logic              p1_rvalid;
  logic [DW-1:0]     p1_rdata;

  // Controller request bus
  logic              m_read;
  logic              m_write;
  logic [AW-1:0]     m_address;
  logic [DW-1:0]     m_wdata;
  logic [DW/8-1:0]   m_wstrb;
  logic [DW-1:0]     m_rdata;

  modport slave (
    input  p0_read, p0_write, p0_address, p0_wdata, p0_wstrb,
    output p0_ready, p0_rvalid, p0_rdata,
    input  p1_read, p1_write, p1_address, p1_wdata, p1_wstrb,
    output p1_ready, p1_rvalid, p1_rdata,
    output m_read, m_write, m_address, m_wdata, m_wstrb,
    input  m_rdata
  );

  modport master (
    output p0_read, p0_write, p0_address, p0_wdata, p0_wstrb,
    input  p0_ready, p0_rvalid, p0_rdata,
    output p1_read, p1_write, p1_address, p1_wdata, p1_wstrb,
    input  p1_ready, p1_rvalid, p1_rdata,
    input  m_read, m_write, m_address, m_wdata, m_wstrb,
    output m_rdata
  );

endinterface

// File: rtl/sram_arb_grant.sv
// sram_arb_grant: pure combinational grant selection for the SRAM arbiter.
// Default: fixed priority (port 0 wins ties) with a forced port-1 grant once
// port 1 has been denied STARVE_MAX cycles in a row.
// With SRAM_ARB_RR_EN defined: round robin on ties, using last_grant
// (0 = port 0 granted last, 1 = port 1 granted last).
module sram_arb_grant
  import sram_arb_pkg::*;
#(
  parameter int STARVE_MAX = 3
) (
  input  logic                    req0,
  input  logic                    req1,
  input  logic [STARVE_CNT_W-1:0] starve_cnt,
  input  logic                    last_grant,
  output grant_e                  grant
);

`ifdef SRAM_ARB_RR_EN

  // The starvation counter has no role under round robin.
  logic unused_starve_cnt;
  assign unused_starve_cnt = ^starve_cnt;

  // Round robin: a tie goes to the port that did not win last time.
  always_comb begin
    grant = GNT_NONE;
    if (req0 && req1) begin
      grant = last_grant ? GNT_P0 : GNT_P1;
    end else if (req0) begin
      grant = GNT_P0;
    end else if (req1) begin
      grant = GNT_P1;
    end
  end

`else

  localparam logic [STARVE_CNT_W-1:0] STARVE_LIMIT = STARVE_CNT_W'(STARVE_MAX);

  // Fixed priority only looks at the starvation counter, not grant history.
  logic unused_last_grant;
  assign unused_last_grant = last_grant;

  // Fixed priority: port 0 first, unless port 1 has waited long enough.
  always_comb begin
    grant = GNT_NONE;
    if (req1 && (starve_cnt == STARVE_LIMIT)) begin
      grant = GNT_P1;
    end else if (req0) begin
      grant = GNT_P0;
    end else if (req1) begin
      grant = GNT_P1;
    end
  end

`endif

endmodule

// File: rtl/sram_arbiter.sv
// sram_arbiter: shares one SRAM controller between a high-priority video
// reader (port 0) and the CPU data port (port 1). One grant per cycle, grant
// is combinational, read responses come back one cycle later with a
// registered rvalid to the port that issued the read.
// Feature macro: SRAM_ARB_RR_EN selects round-robin arbitration; when it is
// undefined, fixed priority with a port-1 starvation guard is used.
module sram_arbiter
  import sram_arb_pkg::*;
#(
  parameter int AW         = 18,
  parameter int DW         = 16,
  parameter int STARVE_MAX = 3
) (
  input  logic          clk,
  input  logic          reset,
  sram_arbiter_if.slave bus
);

  genvar gi;

  // Normalised requests from both ports (write wins, reads unmask all bytes).
  sram_req_t                port_req [N_PORTS];
  logic [N_PORTS-1:0]       port_want;
  logic [N_PORTS-1:0]       port_gnt;
  logic [N_PORTS-1:0]       port_rd_acc;
  logic [N_PORTS-1:0]       rvalid_out;

  grant_e                   grant;
  sram_req_t                sel_req;
  logic [STARVE_CNT_W-1:0]  starve_cnt;
  logic                     last_grant_reg;
  logic                     last_grant_next;
  logic [DW-1:0]            rdata_fwd;
  logic                     unused_sel_addr;

  assign port_req[0] = make_req(bus.p0_read, bus.p0_write,
                                AW_MAX'(bus.p0_address),
                                bus.p0_wdata, bus.p0_wstrb);
  assign port_req[1] = make_req(bus.p1_read, bus.p1_write,
                                AW_MAX'(bus.p1_address),
                                bus.p1_wdata, bus.p1_wstrb);

  // Per-port request qualification, read tracking and response valid.
  // Requests are masked during reset so nothing can be granted then.
  generate
    for (gi = 0; gi < N_PORTS; gi++) begin : g_port
      logic rvalid_reg;

      assign port_want[gi]   = req_active(port_req[gi]) & ~reset;
      assign port_rd_acc[gi] = port_gnt[gi] & port_req[gi].read;

      // Flag the cycle after an accepted read so the port picks up m_rdata.
      always_ff @(posedge clk) begin
        if (reset) begin
          rvalid_reg <= 1'b0;
        end else begin
          rvalid_reg <= port_rd_acc[gi];
        end
      end

      // A read accepted just before reset must not surface during reset.
      assign rvalid_out[gi] = rvalid_reg & ~reset;
    end
  endgenerate

  sram_arb_grant #(
    .STARVE_MAX (STARVE_MAX)
  ) u_grant (
    .req0       (port_want[0]),
    .req1       (port_want[1]),
    .starve_cnt (starve_cnt),
    .last_grant (last_grant_reg),
    .grant      (grant)
  );

  assign port_gnt[0] = (grant == GNT_P0);
  assign port_gnt[1] = (grant == GNT_P1);

`ifndef SRAM_ARB_RR_EN

  localparam logic [STARVE_CNT_W-1:0] STARVE_LIMIT = STARVE_CNT_W'(STARVE_MAX);

  logic [STARVE_CNT_W-1:0] starve_cnt_reg;
  logic [STARVE_CNT_W-1:0] starve_cnt_next;

  // Count consecutive cycles port 1 asks and loses; saturate at the limit,
  // clear as soon as it wins or stops asking.
  always_comb begin
    starve_cnt_next = '0;
    if (port_want[1] && !port_gnt[1]) begin
      if (starve_cnt_reg != STARVE_LIMIT) begin
        starve_cnt_next = starve_cnt_reg + 1'b1;
      end else begin
        starve_cnt_next = starve_cnt_reg;
      end
    end
  end

  // Starvation counter state.
  always_ff @(posedge clk) begin
    if (reset) begin
      starve_cnt_reg <= '0;
    end else begin
      starve_cnt_reg <= starve_cnt_next;
    end
  end

  assign starve_cnt = starve_cnt_reg;

`else

  // Round robin never forces a grant, so the counter stays at zero.
  assign starve_cnt = '0;

`endif

  // Remember which port won most recently (1 = port 1), held when idle.
  always_comb begin
    last_grant_next = last_grant_reg;
    if (port_gnt[0]) begin
      last_grant_next = 1'b0;
    end else if (port_gnt[1]) begin
      last_grant_next = 1'b1;
    end
  end

  // Grant history register; reset favours port 0 on the first tie.
  always_ff @(posedge clk) begin
    if (reset) begin
      last_grant_reg <= 1'b1;
    end else begin
      last_grant_reg <= last_grant_next;
    end
  end

  // Steer the granted port's fields onto the controller bus; idle is all-zero.
  always_comb begin
    sel_req = '0;
    unique case (grant)
      GNT_P0:  sel_req = port_req[0];
      GNT_P1:  sel_req = port_req[1];
      default: sel_req = '0;
    endcase
  end

  // Upper record bits beyond AW are always zero by construction.
  assign unused_sel_addr = ^sel_req.address;

  assign bus.m_read    = sel_req.read;
  assign bus.m_write   = sel_req.write;
  assign bus.m_address = sel_req.address[AW-1:0];
  assign bus.m_wdata   = sel_req.wdata;
  assign bus.m_wstrb   = sel_req.wstrb;

  assign bus.p0_ready  = port_gnt[0];
  assign bus.p1_ready  = port_gnt[1];
  assign bus.p0_rvalid = rvalid_out[0];
  assign bus.p1_rvalid = rvalid_out[1];

  // Both ports see the controller data; rvalid says whose it is.
  assign rdata_fwd     = bus.m_rdata;
  assign bus.p0_rdata  = rdata_fwd;
  assign bus.p1_rdata  = rdata_fwd;

endmodule

// File: tb/tb_sram_arbiter.sv
// tb_sram_arbiter: directed plus randomized checks of sram_arbiter against a
// behavioural reference model and a simple SRAM controller model.
// Honours SRAM_ARB_RR_EN so the same bench covers both arbitration modes.
module tb_sram_arbiter;

  localparam int AW         = 18;
  localparam int DW         = 16;
  localparam int STARVE_MAX = 3;
  localparam int DEPTH      = 1 << AW;

  logic clk   = 1'b0;
  logic reset = 1'b1;

  always #5 clk = ~clk;

  sram_arbiter_if #(.AW(AW), .DW(DW)) bus_if ();

  sram_arbiter #(
    .AW         (AW),
    .DW         (DW),
    .STARVE_MAX (STARVE_MAX)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus_if)
  );

  // Background contents of never-written words.
  function automatic logic [15:0] fill_word(input int a);
    return 16'(a * 37) ^ 16'hA5C3;
  endfunction

  // Byte merge with active-low byte masks.
  function automatic logic [15:0] merge(input logic [15:0] old_w,
                                        input logic [15:0] new_w,
                                        input logic [1:0]  ws);
    logic [15:0] r;
    r[7:0]  = ws[0] ? old_w[7:0]  : new_w[7:0];
    r[15:8] = ws[1] ? old_w[15:8] : new_w[15:8];
    return r;
  endfunction

  // SRAM controller model: acts on the request one cycle after issue.
  logic [15:0] sram [DEPTH];

  initial begin
    for (int i = 0; i < DEPTH; i++) sram[i] = fill_word(i);
  end

  always @(posedge clk) begin
    if (bus_if.m_write)
      sram[bus_if.m_address] <= merge(sram[bus_if.m_address], bus_if.m_wdata, bus_if.m_wstrb);
    if (bus_if.m_read)
      bus_if.m_rdata <= sram[bus_if.m_address];
  end

  // Reference model state.
  logic [15:0] ref_mem [DEPTH];
  int          n_assert = 0;
  int          n_fail   = 0;
  int          cyc      = 0;
  int          streak   = 0;
  bit          last_p1  = 1'b1;
  bit          pend     [2];
  logic [15:0] pend_data[2];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_assert++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s cycle %0d: observed %0h expected %0h", tag, cyc, got, exp);
    end
  endtask

  task automatic set_port(input int p, input bit rd, input bit wr,
                          input logic [AW-1:0] ad, input logic [15:0] wd,
                          input logic [1:0] ws);
    if (p == 0) begin
      bus_if.p0_read = rd; bus_if.p0_write = wr; bus_if.p0_address = ad;
      bus_if.p0_wdata = wd; bus_if.p0_wstrb = ws;
    end else begin
      bus_if.p1_read = rd; bus_if.p1_write = wr; bus_if.p1_address = ad;
      bus_if.p1_wdata = wd; bus_if.p1_wstrb = ws;
    end
  endtask

  task automatic idle_ports();
    set_port(0, 0, 0, '0, '0, '0);
    set_port(1, 0, 0, '0, '0, '0);
  endtask

  // Check one cycle against the model, then advance past the next edge.
  // Entered at posedge+1 with inputs already driven; returns the model grant.
  task automatic run_cycle(output int g);
    bit            rd[2], wr[2], want[2];
    logic [AW-1:0] ad[2];
    logic [15:0]   wd[2];
    logic [1:0]    ws[2];
    bit            is_w, is_r, exp_v;
    #3;
    rd[0] = bus_if.p0_read; wr[0] = bus_if.p0_write; ad[0] = bus_if.p0_address;
    wd[0] = bus_if.p0_wdata; ws[0] = bus_if.p0_wstrb;
    rd[1] = bus_if.p1_read; wr[1] = bus_if.p1_write; ad[1] = bus_if.p1_address;
    wd[1] = bus_if.p1_wdata; ws[1] = bus_if.p1_wstrb;
    for (int p = 0; p < 2; p++) want[p] = !reset && (rd[p] || wr[p]);

    g = -1;
`ifdef SRAM_ARB_RR_EN
    if (want[0] && want[1]) g = last_p1 ? 0 : 1;
    else if (want[0])       g = 0;
    else if (want[1])       g = 1;
`else
    if (want[1] && streak == STARVE_MAX) g = 1;
    else if (want[0])                    g = 0;
    else if (want[1])                    g = 1;
`endif
    is_w = (g >= 0) && wr[g];
    is_r = (g >= 0) && rd[g] && !wr[g];

    check("p0_ready", 32'(bus_if.p0_ready), 32'(g == 0));
    check("p1_ready", 32'(bus_if.p1_ready), 32'(g == 1));
    check("m_read",   32'(bus_if.m_read),   32'(is_r));
    check("m_write",  32'(bus_if.m_write),  32'(is_w));
    if (g >= 0) begin
      check("m_address", 32'(bus_if.m_address), 32'(ad[g]));
      check("m_wstrb",   32'(bus_if.m_wstrb),   is_w ? 32'(ws[g]) : 32'd0);
      if (is_w) check("m_wdata", 32'(bus_if.m_wdata), 32'(wd[g]));
      $display("cycle %0d: grant P%0d %s addr=%05h wdata=%04h wstrb=%b",
               cyc, g, is_w ? "write" : "read", ad[g], wd[g], ws[g]);
    end
    for (int p = 0; p < 2; p++) begin
      exp_v = pend[p] && !reset;
      check(p == 0 ? "p0_rvalid" : "p1_rvalid",
            32'(p == 0 ? bus_if.p0_rvalid : bus_if.p1_rvalid), 32'(exp_v));
      if (exp_v)
        check(p == 0 ? "p0_rdata" : "p1_rdata",
              32'(p == 0 ? bus_if.p0_rdata : bus_if.p1_rdata), 32'(pend_data[p]));
    end

    for (int p = 0; p < 2; p++) begin
      pend[p] = (g == p) && is_r;
      if (pend[p]) pend_data[p] = ref_mem[ad[p]];
    end
    if (is_w) ref_mem[ad[g]] = merge(ref_mem[ad[g]], wd[g], ws[g]);
    if (want[1] && g != 1) streak = (streak < STARVE_MAX) ? streak + 1 : STARVE_MAX;
    else                   streak = 0;
    if (reset)       last_p1 = 1'b1;
    else if (g >= 0) last_p1 = (g == 1);

    @(posedge clk);
    #1;
    cyc++;
  endtask

  initial begin
    int  g;
    int  exp_g;
    bit  hold[2];
    int  kind;
    logic [AW-1:0] ra;

    for (int i = 0; i < DEPTH; i++) ref_mem[i] = fill_word(i);
    pend[0] = 1'b0; pend[1] = 1'b0;
    pend_data[0] = '0; pend_data[1] = '0;
    idle_ports();
    reset = 1'b1;
    @(posedge clk);
    #1;

    // Reset held: everything quiet.
    for (int i = 0; i < 3; i++) run_cycle(g);
    reset = 1'b0;
    run_cycle(g);

    // Single read on port 1.
    set_port(1, 1, 0, 18'h00123, '0, 2'b11);
    run_cycle(g);
    check("single_read_grant", 32'(g), 32'd1);
    idle_ports();
    run_cycle(g);

    // Write 0xBEEF then read it back on port 0.
    set_port(0, 0, 1, 18'h04000, 16'hBEEF, 2'b00);
    run_cycle(g);
    set_port(0, 1, 0, 18'h04000, '0, 2'b00);
    run_cycle(g);
    idle_ports();
    check("wr_rd_rvalid", 32'(bus_if.p0_rvalid), 32'd1);
    check("wr_rd_data",   32'(bus_if.p0_rdata),  32'h0000BEEF);
    run_cycle(g);

    // Read and write together on port 1: treated as a write.
    set_port(1, 1, 1, 18'h00200, 16'h1234, 2'b00);
    run_cycle(g);
    idle_ports();
    run_cycle(g);

    // Continuous contention starting from a fresh reset.
    reset = 1'b1;
    run_cycle(g);
    reset = 1'b0;
    set_port(0, 1, 0, 18'h00300, '0, 2'b00);
    set_port(1, 1, 0, 18'h00400, '0, 2'b00);
    for (int i = 0; i < 12; i++) begin
      run_cycle(g);
`ifdef SRAM_ARB_RR_EN
      exp_g = i % 2;
`else
      exp_g = ((i % (STARVE_MAX + 1)) == STARVE_MAX) ? 1 : 0;
`endif
      check($sformatf("contend_grant_%0d", i), 32'(g), 32'(exp_g));
    end
    idle_ports();
    run_cycle(g);

    // Reset right after an accepted read drops the response.
    set_port(0, 1, 0, 18'h00010, '0, 2'b00);
    run_cycle(g);
    idle_ports();
    reset = 1'b1;
    run_cycle(g);
    run_cycle(g);
    reset = 1'b0;
    run_cycle(g);

    // Randomized traffic honouring the requester hold rule.
    hold[0] = 1'b0; hold[1] = 1'b0;
    for (int i = 0; i < 400; i++) begin
      for (int p = 0; p < 2; p++) begin
        if (!hold[p]) begin
          kind = $urandom_range(0, 5);
          ra   = 18'h00100 + AW'($urandom_range(0, 15));
          set_port(p, (kind == 1 || kind == 2 || kind == 5), (kind == 3 || kind == 4 || kind == 5),
                   ra, 16'($urandom), 2'($urandom));
        end
      end
      reset = ($urandom_range(0, 39) == 0);
      run_cycle(g);
      hold[0] = (bus_if.p0_read || bus_if.p0_write) && (g != 0);
      hold[1] = (bus_if.p1_read || bus_if.p1_write) && (g != 1);
    end
    reset = 1'b0;
    idle_ports();
    run_cycle(g);
    run_cycle(g);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/sram_arbiter.md
# sram_arbiter

Two-port arbiter that shares the single SRAM controller between a high-priority port (port 0, video/screen refresh reader) and a low-priority port (port 1, Hack CPU data memory).
- Sits directly upstream of the SRAM controller and drives its request bus.
- Grants at most one request per cycle.
- Returns read data to the originating port with a registered valid flag.
- Prevents port 1 starvation.

## Interface
Parameters:
- AW, 18, word-address width (matches controller)
- DW, 16, data width; fixed at 16
- STARVE_MAX, 3, consecutive denied port-1 cycles before forced grant; legal range 1..15

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- p0_read / p1_read  in  1  read request
- p0_write / p1_write  in  1  write request
- p0_address / p1_address  in  AW  word address
- p0_wdata / p1_wdata  in  DW  write data
- p0_wstrb / p1_wstrb  in  DW/8  byte mask, forwarded to the controller's active-low byte masks
- p0_ready / p1_ready  out  1  request accepted this cycle
- p0_rvalid / p1_rvalid  out  1  read data valid
- p0_rdata / p1_rdata  out  DW  read data (both ports driven from m_rdata)
- m_read, m_write  out  1  request to SRAM controller
- m_address  out  AW  granted address
- m_wdata  out  DW  granted write data
- m_wstrb  out  DW/8  granted mask
- m_rdata  in  DW  controller read data, valid the cycle after issue

## Operation
- **Request and acceptance:** a port requests when read|write is high. If both are high, the request is treated as a write and the read is ignored.
- **Requester hold rule:** the requester holds address, data and mask stable until ready is high. A transfer completes in the cycle where request && ready.
- **Grant timing:** grant is combinational in the same cycle. The granted port's fields are muxed onto m_*. m_read/m_write are 0 when no port is granted.
- **Read masks:** on reads, m_wstrb = 2'b00 (both bytes enabled).
- **Read return:** px_rvalid is a register set one cycle after an accepted read. Writes produce no rvalid.
- **Fixed-priority arbitration** (default):
  - Port 0 wins ties.
  - starve_cnt increments each cycle port 1 requests and is denied, saturating at STARVE_MAX.
  - starve_cnt clears when port 1 is granted or is not requesting.
  - When starve_cnt == STARVE_MAX, port 1 is granted regardless of port 0.
- **Throughput:** full back-to-back, one grant per cycle. A port can be granted on consecutive cycles.
- **Reset:**
  - During reset: p0_ready = p1_ready = 0, m_read = m_write = 0.
  - Registers clear: rvalid = 0, starve_cnt = 0, last_grant = 1.
  - A read accepted in the cycle before reset is asserted loses its rvalid; that response is dropped.

## Timing
- **Read latency:** accept in cycle N → px_rvalid = 1 in cycle N+1, with px_rdata = m_rdata for the address issued in N.
- **Write:** accept in cycle N → the controller performs it in N+1. No response.
- **Write-then-read:** a read to the same address accepted at N+1 returns the new data at N+2.
- **rvalid pulse:** single-cycle per accepted read. Back-to-back reads give rvalid on consecutive cycles.
- **Output reset values:** all outputs are 0 except p*_rdata, which follows m_rdata.

## Configuration
- **SRAM_ARB_RR_EN defined:** round-robin arbitration.
  - last_grant register (1 bit) updates on every grant.
  - On a tie, the port that was not last granted wins.
  - starve_cnt logic and STARVE_MAX are unused.
- **SRAM_ARB_RR_EN undefined:** fixed priority with the starvation guard described under Operation.

## Structure
- **Package sram_arb_pkg:**
  - enum typedef grant_e {GNT_NONE, GNT_P0, GNT_P1}
  - packed struct sram_req_t {read, write, address, wdata, wstrb}
  - localparam DW = 16
- **Sub-module sram_arb_grant:** pure grant-select logic. Takes both requests, starve_cnt and last_grant; returns grant_e.
- **Top level:** holds the mux, rvalid registers, starve_cnt and last_grant.

## Test plan
- **Single read:** port 1 read at 0x00123, port 0 idle.
  - Same cycle: p1_ready = 1, m_read = 1, m_address = 0x00123.
  - Next cycle: p1_rvalid = 1 and p1_rdata equals the SRAM model's word.
- **Write then read:** port 0 writes 0xBEEF to 0x04000 with wstrb = 00, then reads it back the next cycle → p0_rvalid two cycles after the write, with p0_rdata = 0xBEEF.
- **Starvation guard (fixed priority, STARVE_MAX = 3):** both ports request continuously.
  - Grants follow P0,P0,P0,P1,P0,P0,P0,P1,…
  - p1_rvalid lands exactly one cycle after each P1 grant.
- **Round robin (SRAM_ARB_RR_EN):** both ports request continuously from reset → grants alternate P0,P1,P0,P1,…
- **Read+write on one port:** port 1 asserts read and write together with wdata = 0x1234 → m_write = 1, m_read = 0, and no p1_rvalid.
- **Reset mid-operation:** port 0 read accepted in cycle N, reset high in N+1 → p0_rvalid = 0 in N+1, and all m_* are 0 while reset is held.
